// File: rtl/axi_ddr_responder_pkg.sv
// Shared definitions for the AXI DDR responder slice: response codes, burst
// length width, FSM state types and the beat-size helper.
package axi_resp_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned AXI_LEN_W = 8;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_LOAD,
    R_DATA
  } r_state_e;

  // log2 of bytes per data beat; the only AxSIZE this responder accepts.
  function automatic int unsigned beat_bytes_log2(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/axi_ddr_responder_ram_2p.sv
// Word array backing the AXI responder.
//  clk          clock
//  we/waddr     write enable and word index
//  wbe/wdata    byte enables and write data
//  re/raddr     read enable and word index
//  rdata        registered read data, holds while re=0
module axi_ram_2p #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  // Read and write share the edge, so a same-word collision returns old data.
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (we) begin
      for (int unsigned i = 0; i < DATA_W / 8; i++) begin
        if (wbe[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_ddr_responder.sv
// AXI4 slave memory standing in for the DDR controller. Independent write
// (AW/W/B) and read (AR/R) engines share one word array. INCR bursts only,
// full-width beats only.
//  clk, rst                 clock, asynchronous active-low reset
//  axi_aw*/axi_w*/axi_b*    write address, data and response channels
//  axi_ar*/axi_r*           read address and data channels
//  lock/cache/prot/qos/burst inputs are accepted and ignored
module axi_ddr_responder
  import axi_resp_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 256,
  parameter int unsigned ID_W       = 1,
  parameter int unsigned MEM_ADDR_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ID_W-1:0]      axi_awid,
  input  logic [ADDR_W-1:0]    axi_awaddr,
  input  logic [AXI_LEN_W-1:0] axi_awlen,
  input  logic [2:0]           axi_awsize,
  input  logic [1:0]           axi_awburst,
  input  logic                 axi_awlock,
  input  logic [3:0]           axi_awcache,
  input  logic [2:0]           axi_awprot,
  input  logic [3:0]           axi_awqos,
  input  logic                 axi_awvalid,
  output logic                 axi_awready,
  input  logic [DATA_W-1:0]    axi_wdata,
  input  logic [DATA_W/8-1:0]  axi_wstrb,
  input  logic                 axi_wlast,
  input  logic                 axi_wvalid,
  output logic                 axi_wready,
  output logic [ID_W-1:0]      axi_bid,
  output logic [1:0]           axi_bresp,
  output logic                 axi_bvalid,
  input  logic                 axi_bready,
  input  logic [ID_W-1:0]      axi_arid,
  input  logic [ADDR_W-1:0]    axi_araddr,
  input  logic [AXI_LEN_W-1:0] axi_arlen,
  input  logic [2:0]           axi_arsize,
  input  logic [1:0]           axi_arburst,
  input  logic                 axi_arlock,
  input  logic [3:0]           axi_arcache,
  input  logic [2:0]           axi_arprot,
  input  logic [3:0]           axi_arqos,
  input  logic                 axi_arvalid,
  output logic                 axi_arready,
  output logic [ID_W-1:0]      axi_rid,
  output logic [DATA_W-1:0]    axi_rdata,
  output logic [1:0]           axi_rresp,
  output logic                 axi_rlast,
  output logic                 axi_rvalid,
  input  logic                 axi_rready
);

  localparam int unsigned B         = beat_bytes_log2(DATA_W);
  localparam int unsigned CNT_W     = AXI_LEN_W + 1;
  localparam logic [2:0]  SIZE_FULL = 3'(B);

  // Keeps address ready low while in reset and for the first edge after it.
  logic live_q;

  w_state_e              w_state_d, w_state_q;
  logic [ID_W-1:0]       w_id_d, w_id_q;
  logic [MEM_ADDR_W-1:0] w_idx_d, w_idx_q;
  logic [AXI_LEN_W-1:0]  w_len_d, w_len_q;
  logic [CNT_W-1:0]      w_cnt_d, w_cnt_q;
  logic                  w_err_d, w_err_q;
  logic                  w_bad_size_d, w_bad_size_q;

  r_state_e              r_state_d, r_state_q;
  logic [ID_W-1:0]       r_id_d, r_id_q;
  logic [MEM_ADDR_W-1:0] r_idx_d, r_idx_q;
  logic [AXI_LEN_W-1:0]  r_len_d, r_len_q;
  logic [AXI_LEN_W-1:0]  r_cnt_d, r_cnt_q;
  logic                  r_err_d, r_err_q;

  logic              ram_we, ram_re;
  logic [DATA_W-1:0] ram_rdata;

  axi_ram_2p #(
    .DATA_W (DATA_W),
    .ADDR_W (MEM_ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (w_idx_q),
    .wbe   (axi_wstrb),
    .wdata (axi_wdata),
    .re    (ram_re),
    .raddr (r_idx_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    w_state_d    = w_state_q;
    w_id_d       = w_id_q;
    w_idx_d      = w_idx_q;
    w_len_d      = w_len_q;
    w_cnt_d      = w_cnt_q;
    w_err_d      = w_err_q;
    w_bad_size_d = w_bad_size_q;
    ram_we       = 1'b0;
    case (w_state_q)
      W_IDLE: if (axi_awvalid && live_q) begin
        w_id_d       = axi_awid;
        w_idx_d      = axi_awaddr[B +: MEM_ADDR_W];
        w_len_d      = axi_awlen;
        w_cnt_d      = '0;
        w_bad_size_d = (axi_awsize != SIZE_FULL);
        w_err_d      = (axi_awsize != SIZE_FULL);
        w_state_d    = W_DATA;
      end
      W_DATA: if (axi_wvalid) begin
        ram_we  = !w_bad_size_q;
        w_idx_d = w_idx_q + MEM_ADDR_W'(1);
        // Saturate so an overlong burst stays flagged instead of wrapping.
        if (w_cnt_q != '1) w_cnt_d = w_cnt_q + CNT_W'(1);
        if ((w_cnt_q > {1'b0, w_len_q}) ||
            (axi_wlast && (w_cnt_q != {1'b0, w_len_q}))) w_err_d = 1'b1;
        if (axi_wlast) w_state_d = W_RESP;
      end
      W_RESP: if (axi_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // r_idx_q always names the next word to fetch, so a non-final beat
  // handshake can fetch its successor in the same cycle.
  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_err_d   = r_err_q;
    ram_re    = 1'b0;
    case (r_state_q)
      R_IDLE: if (axi_arvalid && live_q) begin
        r_id_d    = axi_arid;
        r_idx_d   = axi_araddr[B +: MEM_ADDR_W];
        r_len_d   = axi_arlen;
        r_cnt_d   = '0;
        r_err_d   = (axi_arsize != SIZE_FULL);
        r_state_d = R_LOAD;
      end
      R_LOAD: begin
        ram_re    = 1'b1;
        r_idx_d   = r_idx_q + MEM_ADDR_W'(1);
        r_state_d = R_DATA;
      end
      R_DATA: if (axi_rready) begin
        if (r_cnt_q == r_len_q) begin
          r_state_d = R_IDLE;
        end else begin
          ram_re  = 1'b1;
          r_idx_d = r_idx_q + MEM_ADDR_W'(1);
          r_cnt_d = r_cnt_q + AXI_LEN_W'(1);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live_q       <= 1'b0;
      w_state_q    <= W_IDLE;
      w_id_q       <= '0;
      w_idx_q      <= '0;
      w_len_q      <= '0;
      w_cnt_q      <= '0;
      w_err_q      <= 1'b0;
      w_bad_size_q <= 1'b0;
      r_state_q    <= R_IDLE;
      r_id_q       <= '0;
      r_idx_q      <= '0;
      r_len_q      <= '0;
      r_cnt_q      <= '0;
      r_err_q      <= 1'b0;
    end else begin
      live_q       <= 1'b1;
      w_state_q    <= w_state_d;
      w_id_q       <= w_id_d;
      w_idx_q      <= w_idx_d;
      w_len_q      <= w_len_d;
      w_cnt_q      <= w_cnt_d;
      w_err_q      <= w_err_d;
      w_bad_size_q <= w_bad_size_d;
      r_state_q    <= r_state_d;
      r_id_q       <= r_id_d;
      r_idx_q      <= r_idx_d;
      r_len_q      <= r_len_d;
      r_cnt_q      <= r_cnt_d;
      r_err_q      <= r_err_d;
    end
  end

  assign axi_awready = live_q && (w_state_q == W_IDLE);
  assign axi_wready  = (w_state_q == W_DATA);
  assign axi_bvalid  = (w_state_q == W_RESP);
  assign axi_bid     = w_id_q;
  assign axi_bresp   = w_err_q ? RESP_SLVERR : RESP_OKAY;

  assign axi_arready = live_q && (r_state_q == R_IDLE);
  assign axi_rvalid  = (r_state_q == R_DATA);
  assign axi_rid     = r_id_q;
  assign axi_rresp   = (axi_rvalid && r_err_q) ? RESP_SLVERR : RESP_OKAY;
  assign axi_rdata   = (axi_rvalid && !r_err_q) ? ram_rdata : '0;
  assign axi_rlast   = axi_rvalid && (r_cnt_q == r_len_q);

  logic unused_inputs;
  assign unused_inputs = ^{axi_awburst, axi_awlock, axi_awcache, axi_awprot, axi_awqos,
                           axi_awaddr[ADDR_W-1:MEM_ADDR_W+B], axi_awaddr[B-1:0],
                           axi_arburst, axi_arlock, axi_arcache, axi_arprot, axi_arqos,
                           axi_araddr[ADDR_W-1:MEM_ADDR_W+B], axi_araddr[B-1:0]};

endmodule
